// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// abort causes, common command bytes and the frame builder.
package ps2_host_tx_pkg;

    // Transmitter sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INHIBIT  = 4'd1,
        ST_RTS      = 4'd2,
        ST_WAIT1    = 4'd3,
        ST_SHIFT    = 4'd4,
        ST_ACK      = 4'd5,
        ST_WAITIDLE = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } ps2_state_e;

    // Abort causes reported on err_code_o.
    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_FIRST_EDGE = 2'd1;
    localparam logic [1:0] ERR_FRAME      = 2'd2;
    localparam logic [1:0] ERR_NO_ACK     = 2'd3;

    // Frequently used keyboard commands.
    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    // Bits shifted out after the start bit: 8 data, odd parity, stop.
    localparam int unsigned FRAME_BITS = 10;

    // Frame image sent LSB first after the start bit: {stop, odd parity, data}.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Conditioning for one asynchronous PS/2 line: two-flop synchroniser,
// a glitch filter that only accepts a new level after FILT_LEN consecutive
// equal samples, and a registered one-cycle pulse on each filtered 1->0 edge.
module ps2_host_tx_line_filter #(
    parameter int   FILT_LEN   = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Bring the raw pin into the clk_i domain; lines idle high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count, so short glitches vanish.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filtered level, run counter and registered falling-edge pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= IDLE_LEVEL;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Runs the inhibit / request-to-send
// sequence, shifts one command byte out on device-generated clock edges,
// checks the device ACK and reports done or an abort cause. Both pins are
// driven open-drain: *_oe_o = 1 pulls the line low, 0 releases it.
//
// Handshake: the byte on tx_data_i is taken on a cycle where tx_valid_i and
// tx_ready_o are both high. tx_ready_o is high only in IDLE; the producer
// holds tx_valid_i until accepted and nothing is queued while busy.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int INHIBIT_CYC    = 12_000,
    parameter int FIRST_EDGE_CYC = 1_500_000,
    parameter int FRAME_CYC      = 200_000,
    parameter int FILT_LEN       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic [3:0] state_o
);

    // Nonsensical timing values are rejected at elaboration.
    if (CLK_HZ < 1 || INHIBIT_CYC < 1 || FIRST_EDGE_CYC < 1 || FRAME_CYC < 1 || FILT_LEN < 1)
    begin : g_bad_params
        $error("ps2_host_tx: timing parameters must be positive");
    end

    // One shared counter serves the inhibit, first-edge and frame timers.
    localparam int CNT_MAX_A = (INHIBIT_CYC > FIRST_EDGE_CYC) ? INHIBIT_CYC : FIRST_EDGE_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > FRAME_CYC) ? CNT_MAX_A : FRAME_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] FIRST_LAST   = CNT_W'(FIRST_EDGE_CYC - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_CYC - 1);

    // Index of the bit count at which the stop bit goes out (10th fall).
    localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);

    ps2_state_e       state_q;
    ps2_state_e       state_d;
    logic [9:0]       shift_q;
    logic [9:0]       shift_d;
    logic [3:0]       bit_cnt_q;
    logic [3:0]       bit_cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       err_code_q;
    logic [1:0]       err_code_d;
    logic             data_oe_q;
    logic             data_oe_d;
    logic             clk_oe;
    logic             done_pulse;
    logic             err_pulse;

    logic             clk_level;
    logic             clk_fall;
    logic             data_meta_q;
    logic             data_sync_q;

    // PS2_CLK: synchronised, glitch filtered, falling-edge pulse.
    ps2_host_tx_line_filter #(
        .FILT_LEN   (FILT_LEN),
        .IDLE_LEVEL (1'b1)
    ) u_clk_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .line_i  (ps2_clk_i),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    // PS2_DATA only needs a plain two-flop synchroniser; it is sampled
    // on filtered clock edges, long after it has settled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    // Sequencer state, frame shifter, timers and registered data driver.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            err_code_q <= ERR_NONE;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
            data_oe_q  <= data_oe_d;
        end
    end

    // Next-state and line control. Data only changes in the cycle after a
    // filtered fall, i.e. while the device holds the clock low.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        data_oe_d  = data_oe_q;
        clk_oe     = 1'b0;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                cnt_d     = '0;
                if (tx_valid_i) begin
                    shift_d    = ps2_frame(tx_data_i);
                    bit_cnt_d  = '0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                clk_oe = 1'b1;
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;           // start bit
                    state_d   = ST_RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RTS: begin
                clk_oe  = 1'b1;                 // start bit overlaps clock low for one cycle
                state_d = ST_WAIT1;
            end

            ST_WAIT1: begin
                if (cnt_q == FIRST_LAST) begin
                    cnt_d      = '0;
                    data_oe_d  = 1'b0;
                    err_code_d = ERR_FIRST_EDGE;
                    state_d    = ST_ERR;
                end else if (clk_fall) begin
                    cnt_d     = '0;             // frame timer starts at the first fall
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT, ST_ACK, ST_WAITIDLE: begin
                if (cnt_q == FRAME_LAST) begin
                    cnt_d      = '0;
                    data_oe_d  = 1'b0;
                    err_code_d = ERR_FRAME;
                    state_d    = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == ST_SHIFT) begin
                        if (clk_fall) begin
                            data_oe_d = ~shift_q[0];
                            shift_d   = {1'b1, shift_q[9:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == STOP_IDX) begin
                                state_d = ST_ACK;
                            end
                        end
                    end else if (state_q == ST_ACK) begin
                        if (clk_fall) begin
                            if (data_sync_q) begin
                                err_code_d = ERR_NO_ACK;
                                state_d    = ST_ERR;
                            end else begin
                                state_d = ST_WAITIDLE;
                            end
                        end
                    end else begin
                        if (clk_level && data_sync_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                done_pulse = 1'b1;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end

            ST_ERR: begin
                err_pulse = 1'b1;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                data_oe_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign tx_ready_o    = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign tx_done_o     = done_pulse;
    assign tx_err_o      = err_pulse;
    assign err_code_o    = err_code_q;
    assign ps2_clk_oe_o  = clk_oe;
    assign ps2_data_oe_o = data_oe_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural PS/2 keyboard on an open-drain,
// pulled-up wire pair. Timing parameters are shrunk so frames stay short.
module tb_ps2_host_tx;

    localparam int INHIBIT_CYC    = 50;
    localparam int FIRST_EDGE_CYC = 1500;
    localparam int FRAME_CYC      = 1200;
    localparam int FILT_LEN       = 4;
    localparam int HALF           = 20;     // device clock half period in clk cycles
    localparam int WATCH_BOUND    = INHIBIT_CYC + FIRST_EDGE_CYC + FRAME_CYC + 500;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [3:0] state_dbg;

    // Device side of the wired-AND lines (1 = released).
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    wire  ps2_clk_pin  = ~ps2_clk_oe & dev_clk;
    wire  ps2_data_pin = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .CLK_HZ         (100_000_000),
        .INHIBIT_CYC    (INHIBIT_CYC),
        .FIRST_EDGE_CYC (FIRST_EDGE_CYC),
        .FRAME_CYC      (FRAME_CYC),
        .FILT_LEN       (FILT_LEN)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .tx_done_o     (tx_done),
        .tx_err_o      (tx_err),
        .err_code_o    (err_code),
        .busy_o        (busy),
        .ps2_clk_i     (ps2_clk_pin),
        .ps2_data_i    (ps2_data_pin),
        .ps2_clk_oe_o  (ps2_clk_oe),
        .ps2_data_oe_o (ps2_data_oe),
        .state_o       (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec   = 0;
    int n_fail  = 0;
    int cur_vec = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h, want %0h", name, cur_vec, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Bits the device should capture after the start bit: data LSB first,
    // then a parity bit making the total count of ones odd, then stop=1.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // Outcome for a device that produces n_edges clock pulses and
    // optionally pulls data low for the 11th.
    function automatic logic [1:0] exp_code_of(input int n_edges, input bit ack);
        if (n_edges == 0) return 2'd1;
        if (n_edges < 11) return 2'd2;
        if (ack) return 2'd0;
        return 2'd3;
    endfunction

    typedef struct {
        logic [7:0] data;
        int         n_edges;
        bit         ack;
        logic [1:0] exp_code;
        bit         exp_done;
    } vec_t;

    vec_t vecs[$];

    // ---------------- device model ----------------
    task automatic device(input int n_edges, input bit ack, output logic [9:0] cap);
        int w;
        cap = '0;
        if (n_edges == 0) return;
        w = 0;
        while (!(ps2_clk_pin === 1'b1 && ps2_data_pin === 1'b0) && w < 20000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 20000) return;
        repeat (HALF) @(posedge clk);
        #1;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            #1;
            dev_clk = 1'b1;
            if (k <= 10) cap[k-1] = ps2_data_pin;
            repeat (HALF) @(posedge clk);
            #1;
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    // Observe the host from just after accept until a done/err pulse.
    task automatic watch(output int inh, output int ovl, output int rel_cyc, output int pulse_cyc,
                         output int n_done, output int n_err, output int n_both, output int oe_rises);
        logic prev_oe;
        inh = 0; ovl = 0; rel_cyc = -1; pulse_cyc = -1;
        n_done = 0; n_err = 0; n_both = 0; oe_rises = 0;
        prev_oe = 1'b0;
        for (int cyc = 0; cyc < WATCH_BOUND; cyc++) begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                inh++;
                if (ps2_data_oe) ovl++;
                if (!prev_oe) oe_rises++;
            end else if (prev_oe && rel_cyc < 0) begin
                rel_cyc = cyc;
            end
            prev_oe = ps2_clk_oe;
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            if (tx_done && tx_err) n_both++;
            if (tx_done || tx_err) begin
                pulse_cyc = cyc;
                break;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic accept(input logic [7:0] d, input bit hold);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        chk("ready_before_accept", tx_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        chk("accept_clk_oe", ps2_clk_oe, 1);
        chk("accept_busy", busy, 1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0] cap;
        int inh, ovl, rel, pc, nd, ne, nb, rises;
        accept(v.data, 1'b0);
        fork
            device(v.n_edges, v.ack, cap);
            begin
                watch(inh, ovl, rel, pc, nd, ne, nb, rises);
                chk("pulse_seen", (pc >= 0), 1);
                chk("inhibit_cycles", inh, INHIBIT_CYC + 1);
                chk("rts_overlap", ovl, 1);
                chk("done_pulse", nd, v.exp_done);
                chk("err_pulse", ne, !v.exp_done);
                chk("done_err_same_cycle", nb, 0);
                chk("err_code", err_code, v.exp_code);
                if (v.exp_code == 2'd1) chk("first_edge_timing", pc - rel, FIRST_EDGE_CYC);
                @(negedge clk);
                chk("busy_after_pulse", busy, 0);
                chk("ready_after_pulse", tx_ready, 1);
                chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
            end
        join
        if (v.n_edges >= 10) chk("frame_bits", cap, exp_frame(v.data));
        repeat (5) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] cap;
        int inh, ovl, rel, pc, nd, ne, nb, rises, w, pulses;
        vec_t v;

        vecs.push_back('{8'hED, 11, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{8'hF4, 11, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{8'hFF, 11, 1'b1, 2'd0, 1'b1});
        vecs.push_back('{8'h55,  0, 1'b0, 2'd1, 1'b0});
        vecs.push_back('{8'hA5,  5, 1'b1, 2'd2, 1'b0});
        vecs.push_back('{8'h3C, 11, 1'b0, 2'd3, 1'b0});
        for (int i = 0; i < 10; i++) begin
            int mode;
            v.data = 8'($urandom_range(0, 255));
            mode   = int'($urandom_range(0, 3));
            v.n_edges = (mode == 0 || mode == 1) ? 11 : (mode == 2) ? int'($urandom_range(1, 10)) : 0;
            v.ack      = (mode != 1);
            v.exp_code = exp_code_of(v.n_edges, v.ack);
            v.exp_done = (v.exp_code == 2'd0);
            vecs.push_back(v);
        end

        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_pulses", {tx_done, tx_err}, 0);
        chk("reset_err_code", err_code, 0);
        chk("reset_lines", {ps2_clk_oe, ps2_data_oe}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // Reset in the middle of the data bits.
        cur_vec = 100;
        accept(8'h00, 1'b0);
        device(4, 1'b0, cap);
        @(negedge clk);
        chk("shift_in_progress", ps2_data_oe, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err_code", err_code, 0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_done || tx_err) pulses++;
        end
        chk("rst_no_pulse", pulses, 0);

        // Narrow glitches on PS2_CLK while waiting for the first edge.
        cur_vec = 101;
        accept(8'h01, 1'b0);
        w = 0;
        while (ps2_clk_oe && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("clock_released", ps2_clk_oe, 0);
        repeat (20) begin
            @(posedge clk);
            #3 dev_clk = 1'b0;
            #1 dev_clk = 1'b1;
        end
        @(negedge clk);
        chk("glitch_no_fall", ps2_data_oe, 1);
        chk("glitch_no_err", tx_err, 0);
        chk("glitch_busy", busy, 1);
        fork
            device(11, 1'b1, cap);
            watch(inh, ovl, rel, pc, nd, ne, nb, rises);
        join
        chk("glitch_frame_done", nd, 1);
        chk("glitch_frame_bits", cap, exp_frame(8'h01));
        repeat (5) @(negedge clk);

        // tx_valid held for the whole frame and through the tx_done cycle.
        cur_vec = 102;
        accept(8'hF4, 1'b1);
        fork
            device(11, 1'b1, cap);
            watch(inh, ovl, rel, pc, nd, ne, nb, rises);
        join
        chk("held_done", nd, 1);
        chk("held_single_inhibit", rises, 1);
        chk("held_frame_bits", cap, exp_frame(8'hF4));
        chk("done_cycle_not_ready", tx_ready, 0);
        @(posedge clk);
        #1;
        chk("no_accept_in_done", ps2_clk_oe, 0);
        chk("idle_after_done", {busy, tx_ready}, 2'b01);
        @(posedge clk);
        #1;
        chk("accept_after_done", ps2_clk_oe, 1);
        tx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("final_idle", tx_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1);
    end

endmodule
